rom_fetch_arbiter: RTL
======================

// Module: rom_fetch_arbiter
// PURPOSE
//  Shares the single-port combinational instruction ROM between two requesters.
//  Port A is CPU instruction fetch and has priority. Port B is the debug/UART
//  dump port and issues multi-word read bursts.
//  Returns registered read data one cycle after each grant.
//  Anti-starvation: port B is guaranteed a beat after MAX_WAIT consecutive cycles lost to port A.
// PARAMETERS
//  ROM_WORDS  128  ROM depth in 32-bit words (power of 2); word index = addr[log2(ROM_WORDS)+1:2]
//  MAX_WAIT   8    consecutive B-pending cycles lost to A before B is forced a grant (>=1)
//  BLEN_W     8    width of b_len; burst length = b_len+1 beats
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  a_req      in   1       fetch request (combinational, held until a_gnt)
//  a_addr     in   32      fetch byte address
//  a_gnt      out  1       combinational: A owns the ROM this cycle
//  a_rvalid   out  1       registered: a_rdata valid (cycle after a_gnt)
//  a_rdata    out  32      fetch data
//  a_err      out  1       address error, qualifies a_rvalid (feature-gated)
//  b_req      in   1       burst start request; sampled only in IDLE
//  b_addr     in   32      burst base byte address
//  b_len      in   BLEN_W  beats minus 1
//  b_busy     out  1       burst in progress (B_BURST state)
//  b_gnt      out  1       combinational: a B beat owns the ROM this cycle
//  b_rvalid   out  1       registered beat data valid
//  b_rdata    out  32      beat data
//  b_done     out  1       1-cycle pulse with the last beat's b_rvalid (or with the reject)
//  b_err      out  1       burst rejected (feature-gated)
//  rom_addr   out  32      combinational address to ROM
//  rom_data   in   32      combinational ROM read data
// BEHAVIOUR
//  Reset: FSM=IDLE; wait_cnt=0; all registered outputs 0; rom_addr=a_addr.
//  FSM IDLE: if b_req, capture base=b_addr and rem=b_len, then enter B_BURST next cycle.
//    b_req is ignored while in B_BURST.
//  B grant: force = (wait_cnt==MAX_WAIT).
//    b_gnt = B_BURST & (!a_req | force).
//  A grant: a_gnt = a_req & !b_gnt.
//    A is never blocked in IDLE; A loses at most one cycle per MAX_WAIT+1 cycles.
//  rom_addr: {base[31:2+log2(ROM_WORDS)], idx, 2'b00} when b_gnt, else a_addr.
//  Latency: on a grant cycle, rom_data is registered into x_rdata and x_rvalid=1
//    for exactly the next cycle. x_rvalid is 0 otherwise; x_rdata holds its last value.
//  wait_cnt:
//    +1 per B_BURST cycle where a_gnt=1 (saturates at MAX_WAIT).
//    Cleared on b_gnt.
//    Cleared in IDLE.
//  Burst beats:
//    On each b_gnt, idx=(idx+1) mod ROM_WORDS (wrap to word 0) and rem decrements.
//    On the beat with rem==0: FSM returns to IDLE and b_done pulses with that beat's b_rvalid.
//  Back-to-back: a new b_req in the cycle after IDLE re-entry is accepted.
//    The B_BURST entry cycle after capture may grant immediately.
//  Reset mid-burst aborts: no b_done, no rvalid; pending data is discarded.
// CONFIGURATION
//  ROM_ERR_CHECK_EN defined:
//    A, a_addr[1:0]!=0 or word index>=ROM_WORDS: a_gnt still asserts; ROM is not used.
//      Next cycle a_rvalid=1, a_err=1, a_rdata=32'h0800_0000 (j 0).
//    B, b_addr[1:0]!=0 at burst start: burst rejected, no beats;
//      next cycle b_err=1 and b_done=1, b_rvalid=0; FSM stays IDLE.
//    Errors are 1-cycle pulses.
//  ROM_ERR_CHECK_EN undefined: a_err=b_err=0 always.
//    Addresses are passed through unchecked; only the word index bits matter.
// TESTING
//  1 A only: a_req every cycle, a_addr=0,4,8 -> a_gnt=1 each cycle;
//    a_rvalid next cycle with rom_data of words 0,1,2; b_* all 0.
//  2 B only: b_addr=0x10, b_len=3 -> b_busy for 4 beats;
//    rom_addr=0x10,0x14,0x18,0x1C; b_done with 4th b_rvalid.
//  3 Starvation: B burst of 2 with a_req held high, MAX_WAIT=8 ->
//    b_gnt after 8 A grants, a_gnt=0 on that cycle, repeat for 2nd beat.
//  4 Wrap: ROM_WORDS=128, b_addr=0x1F8, b_len=2 -> beat addresses 0x1F8,0x1FC,0x000.
//  5 Reset mid-burst: assert reset on 2nd beat of b_len=5 ->
//    all outputs 0 immediately; after release IDLE, no b_done.
//  6 ROM_ERR_CHECK_EN: a_addr=0x202 -> a_err=1, a_rdata=0x08000000;
//    b_addr=0x3 -> b_err=b_done=1, no b_gnt.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one combinational instruction ROM between the CPU
// fetch port (A, priority) and a debug burst-read port (B). Read data returns
// registered one cycle after each grant. B is forced a beat after MAX_WAIT
// consecutive cycles lost to A.
// Optional feature macro: ROM_ERR_CHECK_EN enables address error checking
// (a_err / b_err); without it both error outputs stay 0.
module rom_fetch_arbiter #(
  parameter int unsigned ROM_WORDS = 128,
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned BLEN_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_a_req,
  input  logic [31:0]       i_a_addr,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic [31:0]       o_a_rdata,
  output logic              o_a_err,
  input  logic              i_b_req,
  input  logic [31:0]       i_b_addr,
  input  logic [BLEN_W-1:0] i_b_len,
  output logic              o_b_busy,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [31:0]       o_b_rdata,
  output logic              o_b_done,
  output logic              o_b_err,
  output logic [31:0]       o_rom_addr,
  input  logic [31:0]       i_rom_data
);

  localparam int unsigned IW = $clog2(ROM_WORDS);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] ErrInsn = 32'h0800_0000;  // "j 0"

  typedef enum logic [0:0] {StIdle, StBBurst} state_e;

  state_e             r_state;
  logic [31-IW-2:0]   r_base_hi;
  logic [IW-1:0]      r_idx;
  logic [BLEN_W-1:0]  r_rem;
  logic [WW-1:0]      r_wait_cnt;
  logic               r_a_rvalid;
  logic [31:0]        r_a_rdata;
  logic               r_a_err;
  logic               r_b_rvalid;
  logic [31:0]        r_b_rdata;
  logic               r_b_done;
  logic               r_b_err;

  logic w_force;
  logic w_b_gnt;
  logic w_a_gnt;
  logic w_b_last;
  logic w_a_bad;
  logic w_b_bad;

`ifdef ROM_ERR_CHECK_EN
  // Misaligned, or beyond the last ROM word.
  assign w_a_bad = (i_a_addr[1:0] != 2'b00) | (i_a_addr[31:IW+2] != '0);
  assign w_b_bad = (i_b_addr[1:0] != 2'b00);
`else
  logic w_unused_b_addr;
  assign w_unused_b_addr = ^i_b_addr[1:0];
  assign w_a_bad = 1'b0;
  assign w_b_bad = 1'b0;
`endif

  assign w_force  = (r_wait_cnt == WW'(MAX_WAIT));
  assign w_b_gnt  = (r_state == StBBurst) & (~i_a_req | w_force);
  assign w_a_gnt  = i_a_req & ~w_b_gnt;
  assign w_b_last = (r_rem == '0);

  assign o_a_gnt    = w_a_gnt;
  assign o_b_gnt    = w_b_gnt;
  assign o_b_busy   = (r_state == StBBurst);
  assign o_rom_addr = w_b_gnt ? {r_base_hi, r_idx, 2'b00} : i_a_addr;

  assign o_a_rvalid = r_a_rvalid;
  assign o_a_rdata  = r_a_rdata;
  assign o_a_err    = r_a_err;
  assign o_b_rvalid = r_b_rvalid;
  assign o_b_rdata  = r_b_rdata;
  assign o_b_done   = r_b_done;
  assign o_b_err    = r_b_err;

  // Burst FSM: capture, beat sequencing, starvation counter and B read return.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_base_hi  <= '0;
      r_idx      <= '0;
      r_rem      <= '0;
      r_wait_cnt <= '0;
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= '0;
      r_b_done   <= 1'b0;
      r_b_err    <= 1'b0;
    end else begin
      r_b_rvalid <= w_b_gnt;
      r_b_done   <= w_b_gnt & w_b_last;
      r_b_err    <= 1'b0;
      if (w_b_gnt) begin
        r_b_rdata <= i_rom_data;
      end
      case (r_state)
        StIdle: begin
          r_wait_cnt <= '0;
          if (i_b_req) begin
            if (w_b_bad) begin
              // Rejected burst: report and stay idle, no beats issued.
              r_b_err  <= 1'b1;
              r_b_done <= 1'b1;
            end else begin
              r_base_hi <= i_b_addr[31:IW+2];
              r_idx     <= i_b_addr[IW+1:2];
              r_rem     <= i_b_len;
              r_state   <= StBBurst;
            end
          end
        end
        StBBurst: begin
          if (w_b_gnt) begin
            r_wait_cnt <= '0;
            r_idx      <= r_idx + IW'(1);
            r_rem      <= r_rem - BLEN_W'(1);
            if (w_b_last) begin
              r_state <= StIdle;
            end
          end else if (w_a_gnt && !w_force) begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Port A read return: data (or error word) one cycle after each A grant.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_a_err    <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_gnt;
      r_a_err    <= w_a_gnt & w_a_bad;
      if (w_a_gnt) begin
        r_a_rdata <= w_a_bad ? ErrInsn : i_rom_data;
      end
    end
  end

endmodule
